// File: rtl/fpu_host_if.sv
// Host-side request/response signals and the 8-bit FPU register bus of fpu_host.
// The slave modport is the fpu_host view. The master modport is the view of the environment around it.
interface fpu_host_if;
  logic        start;
  logic        op;
  logic [31:0] y_in;
  logic [31:0] x_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        error;
  logic        fpu_sel;
  logic        fpu_read;
  logic        fpu_write;
  logic [1:0]  fpu_addr;
  logic [7:0]  fpu_wdata;
  logic [7:0]  fpu_rdata;

  modport master (
    output start, op, y_in, x_in, fpu_rdata,
    input  busy, done, result, error,
    input  fpu_sel, fpu_read, fpu_write, fpu_addr, fpu_wdata
  );

  modport slave (
    input  start, op, y_in, x_in, fpu_rdata,
    output busy, done, result, error,
    output fpu_sel, fpu_read, fpu_write, fpu_addr, fpu_wdata
  );
endinterface

// File: rtl/fpu_host.sv
// fpu_host: loads Y and X into an 8-bit bus FPU and issues divide or multiply. It then polls status and reads the 32-bit result.
// Optional poll timeout is enabled by defining FPU_HOST_TIMEOUT_EN.
module fpu_host #(
  parameter int SETTLE     = 2,
  parameter int POLL_LIMIT = 255
) (
  input  logic      clk,
  input  logic      reset,
  fpu_host_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD_Y,
    S_VAL_Y,
    S_CMD_X,
    S_VAL_X,
    S_CMD_OP,
    S_SETTLE,
    S_POLL,
    S_READ,
    S_DONE
  } state_t;

  localparam logic [1:0] ADDR_STATUS = 2'b00;
  localparam logic [1:0] ADDR_RESULT = 2'b01;
  localparam logic [1:0] ADDR_CMD    = 2'b10;
  localparam logic [1:0] ADDR_VALUE  = 2'b11;

  localparam logic [7:0] CMD_LOAD_Y = 8'h01;
  localparam logic [7:0] CMD_LOAD_X = 8'h02;
  localparam logic [7:0] CMD_DIV    = 8'h03;
  localparam logic [7:0] CMD_MUL    = 8'h04;

  localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  if (SETTLE < 0) begin : g_bad_settle
    $error("fpu_host: SETTLE must be non-negative");
  end
  if (POLL_LIMIT < 1 || POLL_LIMIT > 255) begin : g_bad_poll_limit
    $error("fpu_host: POLL_LIMIT must be in 1..255");
  end

  state_t           state_q, state_d;
  logic             gap_q, gap_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [SCW-1:0]   settle_cnt_q, settle_cnt_d;
  logic [31:0]      y_q, y_d;
  logic [31:0]      x_q, x_d;
  logic             op_q, op_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      result_q, result_d;
  logic             poll_busy_q, poll_busy_d;

`ifdef FPU_HOST_TIMEOUT_EN
  localparam logic [7:0] POLL_LIMIT_B = 8'(POLL_LIMIT);
  logic [7:0]       poll_cnt_q, poll_cnt_d;
  logic             error_q, error_d;
`endif

  // Operand bytes ordered for transmission: index 0 is the most significant byte.
  logic [7:0] y_bytes [4];
  logic [7:0] x_bytes [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bytes
      assign y_bytes[gi] = y_q[31 - 8*gi -: 8];
      assign x_bytes[gi] = x_q[31 - 8*gi -: 8];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      gap_q        <= 1'b0;
      byte_cnt_q   <= 2'd0;
      settle_cnt_q <= '0;
      y_q          <= 32'd0;
      x_q          <= 32'd0;
      op_q         <= 1'b0;
      acc_q        <= 32'd0;
      result_q     <= 32'd0;
      poll_busy_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      byte_cnt_q   <= byte_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      y_q          <= y_d;
      x_q          <= x_d;
      op_q         <= op_d;
      acc_q        <= acc_d;
      result_q     <= result_d;
      poll_busy_q  <= poll_busy_d;
    end
  end

`ifdef FPU_HOST_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      poll_cnt_q <= 8'd0;
      error_q    <= 1'b0;
    end else begin
      poll_cnt_q <= poll_cnt_d;
      error_q    <= error_d;
    end
  end
`endif

  // Next state. Every bus state alternates a strobe cycle (gap_q=0) with a gap cycle (gap_q=1).
  // Transitions out of a bus state happen only at the end of its gap cycle.
  always_comb begin
    state_d      = state_q;
    gap_d        = gap_q;
    byte_cnt_d   = byte_cnt_q;
    settle_cnt_d = settle_cnt_q;
    y_d          = y_q;
    x_d          = x_q;
    op_d         = op_q;
    acc_d        = acc_q;
    result_d     = result_q;
    poll_busy_d  = poll_busy_q;
`ifdef FPU_HOST_TIMEOUT_EN
    poll_cnt_d   = poll_cnt_q;
    error_d      = error_q;
`endif

    case (state_q)
      S_IDLE: begin
        gap_d = 1'b0;
        if (bus.start) begin
          y_d        = bus.y_in;
          x_d        = bus.x_in;
          op_d       = bus.op;
          byte_cnt_d = 2'd0;
          state_d    = S_CMD_Y;
`ifdef FPU_HOST_TIMEOUT_EN
          poll_cnt_d = 8'd0;
          error_d    = 1'b0;
`endif
        end
      end

      S_CMD_Y: begin
        gap_d = ~gap_q;
        if (gap_q) state_d = S_VAL_Y;
      end

      S_VAL_Y: begin
        gap_d = ~gap_q;
        if (gap_q) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = S_CMD_X;
        end
      end

      S_CMD_X: begin
        gap_d = ~gap_q;
        if (gap_q) state_d = S_VAL_X;
      end

      S_VAL_X: begin
        gap_d = ~gap_q;
        if (gap_q) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = S_CMD_OP;
        end
      end

      S_CMD_OP: begin
        gap_d = ~gap_q;
        if (gap_q) begin
          settle_cnt_d = '0;
          state_d      = (SETTLE == 0) ? S_POLL : S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (settle_cnt_q == SCW'(SETTLE - 1)) state_d = S_POLL;
        else                                  settle_cnt_d = settle_cnt_q + 1'b1;
      end

      S_POLL: begin
        gap_d = ~gap_q;
        if (!gap_q) begin
          poll_busy_d = bus.fpu_rdata[7];
`ifdef FPU_HOST_TIMEOUT_EN
          poll_cnt_d  = poll_cnt_q + 8'd1;
`endif
        end else if (!poll_busy_q) begin
          byte_cnt_d = 2'd0;
          state_d    = S_READ;
        end
`ifdef FPU_HOST_TIMEOUT_EN
        // Give up once the limit of consecutive busy polls is reached; result keeps its old value.
        else if (poll_cnt_q == POLL_LIMIT_B) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end
`endif
      end

      S_READ: begin
        gap_d = ~gap_q;
        if (!gap_q) begin
          acc_d = {acc_q[23:0], bus.fpu_rdata};
        end else begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            result_d = acc_q;
            state_d  = S_DONE;
          end
        end
      end

      S_DONE: begin
        gap_d   = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        gap_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus strobes are decoded straight from registered state. An asynchronous reset therefore drops them at once.
  always_comb begin
    bus.fpu_sel   = 1'b0;
    bus.fpu_read  = 1'b0;
    bus.fpu_write = 1'b0;
    bus.fpu_addr  = 2'b00;
    bus.fpu_wdata = 8'h00;
    if (!gap_q) begin
      case (state_q)
        S_CMD_Y: begin
          bus.fpu_sel   = 1'b1;
          bus.fpu_write = 1'b1;
          bus.fpu_addr  = ADDR_CMD;
          bus.fpu_wdata = CMD_LOAD_Y;
        end
        S_VAL_Y: begin
          bus.fpu_sel   = 1'b1;
          bus.fpu_write = 1'b1;
          bus.fpu_addr  = ADDR_VALUE;
          bus.fpu_wdata = y_bytes[byte_cnt_q];
        end
        S_CMD_X: begin
          bus.fpu_sel   = 1'b1;
          bus.fpu_write = 1'b1;
          bus.fpu_addr  = ADDR_CMD;
          bus.fpu_wdata = CMD_LOAD_X;
        end
        S_VAL_X: begin
          bus.fpu_sel   = 1'b1;
          bus.fpu_write = 1'b1;
          bus.fpu_addr  = ADDR_VALUE;
          bus.fpu_wdata = x_bytes[byte_cnt_q];
        end
        S_CMD_OP: begin
          bus.fpu_sel   = 1'b1;
          bus.fpu_write = 1'b1;
          bus.fpu_addr  = ADDR_CMD;
          bus.fpu_wdata = op_q ? CMD_MUL : CMD_DIV;
        end
        S_POLL: begin
          bus.fpu_sel  = 1'b1;
          bus.fpu_read = 1'b1;
          bus.fpu_addr = ADDR_STATUS;
        end
        S_READ: begin
          bus.fpu_sel  = 1'b1;
          bus.fpu_read = 1'b1;
          bus.fpu_addr = ADDR_RESULT;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;

`ifdef FPU_HOST_TIMEOUT_EN
  assign bus.error = error_q;
`else
  assign bus.error = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_host.sv
// Bench for fpu_host. It uses a behavioural bus FPU, directed cases and randomized integer-valued float operations.
// Results are computed from real arithmetic and compared against the DUT.
module tb_fpu_host;
  localparam int SETTLE     = 2;
  localparam int POLL_LIMIT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fpu_host_if bus ();

  fpu_host #(.SETTLE(SETTLE), .POLL_LIMIT(POLL_LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_res = 32'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- float helpers (normal numbers only) ----------------
  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) repeat (e) r = r * 2.0;
    else        repeat (-e) r = r / 2.0;
    return r;
  endfunction

  function automatic real f2r(input logic [31:0] b);
    real r;
    if (b[30:23] == 8'd0) return 0.0;
    r = (1.0 + real'(b[22:0]) / 8388608.0) * pow2(int'(b[30:23]) - 127);
    return b[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2f(input real v);
    logic        s;
    real         a;
    int          e;
    logic [22:0] m;
    if (v == 0.0) return 32'd0;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m = 23'($rtoi((a - 1.0) * 8388608.0));
    return {s, 8'(e + 127), m};
  endfunction

  function automatic logic [31:0] fpu_calc(input logic mul, input logic [31:0] y, input logic [31:0] x);
    return r2f(mul ? f2r(y) * f2r(x) : f2r(y) / f2r(x));
  endfunction

  // ---------------- behavioural FPU on the bus ----------------
  logic [7:0]  cmd_m = 8'h00;
  logic [31:0] y_m = 32'd0, x_m = 32'd0, res_m = 32'd0;
  int          busy_left = 0, rd_idx = 0, busy_cfg = 0, status_reads = 0;
  bit          busy_forever = 1'b0;
  logic [9:0]  wr_q[$];

  always @(posedge clk) begin
    if (bus.fpu_sel && bus.fpu_write) begin
      wr_q.push_back({bus.fpu_addr, bus.fpu_wdata});
      if (bus.fpu_addr == 2'b10) begin
        cmd_m <= bus.fpu_wdata;
        if (bus.fpu_wdata == 8'h03 || bus.fpu_wdata == 8'h04) begin
          res_m     <= fpu_calc(bus.fpu_wdata == 8'h04, y_m, x_m);
          busy_left <= busy_cfg;
          rd_idx    <= 0;
        end
      end else if (bus.fpu_addr == 2'b11) begin
        if (cmd_m == 8'h01)      y_m <= {y_m[23:0], bus.fpu_wdata};
        else if (cmd_m == 8'h02) x_m <= {x_m[23:0], bus.fpu_wdata};
      end
    end
    if (bus.fpu_sel && bus.fpu_read) begin
      if (bus.fpu_addr == 2'b00) begin
        status_reads <= status_reads + 1;
        if (busy_left > 0) busy_left <= busy_left - 1;
      end else if (bus.fpu_addr == 2'b01) begin
        rd_idx <= rd_idx + 1;
      end
    end
  end

  always_comb begin
    bus.fpu_rdata = 8'h00;
    if (bus.fpu_addr == 2'b00) begin
      bus.fpu_rdata = {(busy_forever || busy_left > 0), 7'h00};
    end else if (bus.fpu_addr == 2'b01) begin
      case (rd_idx)
        0:       bus.fpu_rdata = res_m[31:24];
        1:       bus.fpu_rdata = res_m[23:16];
        2:       bus.fpu_rdata = res_m[15:8];
        3:       bus.fpu_rdata = res_m[7:0];
        default: bus.fpu_rdata = 8'h00;
      endcase
    end
  end

  // ---------------- bus protocol monitor ----------------
  logic prev_sel = 1'b0;
  logic proto_ok;
  assign proto_ok = !(bus.fpu_read && bus.fpu_write)
                 && (bus.fpu_sel == (bus.fpu_read || bus.fpu_write))
                 && (bus.fpu_write || bus.fpu_wdata == 8'h00)
                 && !(prev_sel && bus.fpu_sel);

  always @(negedge clk) begin
    if (!reset) check_eq("bus_proto", 32'(proto_ok), 32'd1);
    prev_sel <= bus.fpu_sel;
  end

  // ---------------- stimulus helpers ----------------
  task automatic check_trace(input string tag, input logic opv, input logic [31:0] yv, input logic [31:0] xv);
    logic [9:0] e [11];
    e[0]  = {2'b10, 8'h01};
    e[5]  = {2'b10, 8'h02};
    e[10] = {2'b10, (opv ? 8'h04 : 8'h03)};
    for (int i = 0; i < 4; i++) begin
      e[1 + i] = {2'b11, yv[31 - 8*i -: 8]};
      e[6 + i] = {2'b11, xv[31 - 8*i -: 8]};
    end
    check_eq({tag, "_trace_len"}, 32'(wr_q.size()), 32'd11);
    for (int i = 0; i < 11; i++)
      if (i < wr_q.size()) check_eq($sformatf("%s_tr%0d", tag, i), 32'(wr_q[i]), 32'(e[i]));
  endtask

  // Starts one operation from IDLE (called right after a falling edge). Optionally re-asserts start
  // with different operands at cycle inj_cyc, then checks latency, result, trace and the single done pulse.
  task automatic run_op(input string tag, input logic opv, input logic [31:0] yv, input logic [31:0] xv,
                        input int busy_n, input logic [31:0] exp_res, input int inj_cyc);
    int cyc;
    int extra_done;
    wr_q.delete();
    busy_cfg     = busy_n;
    busy_forever = 1'b0;
    bus.op       = opv;
    bus.y_in     = yv;
    bus.x_in     = xv;
    bus.start    = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); @(negedge clk); cyc++;
      if (cyc == 1) begin
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd1);
        check_eq({tag, "_err_clr"}, 32'(bus.error), 32'd0);
      end
      if (cyc == inj_cyc) begin
        bus.start = 1'b1;
        bus.op    = ~opv;
        bus.y_in  = ~yv;
        bus.x_in  = yv ^ xv ^ 32'h1;
      end else begin
        bus.start = 1'b0;
      end
    end while (!bus.done && cyc < 400);
    check_eq({tag, "_latency"}, 32'(cyc), 32'(33 + SETTLE + 2*busy_n));
    check_eq({tag, "_result"}, bus.result, exp_res);
    check_eq({tag, "_error"}, 32'(bus.error), 32'd0);
    check_eq({tag, "_busy_in_done"}, 32'(bus.busy), 32'd1);
    check_trace(tag, opv, yv, xv);
    extra_done = 0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      if (bus.done || bus.busy) extra_done++;
    end
    check_eq({tag, "_idle_after"}, 32'(extra_done), 32'd0);
    check_eq({tag, "_result_held"}, bus.result, exp_res);
    last_res = exp_res;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          cyc;
    int          a, b;
    logic        opv;
    int          bn;
    logic [31:0] yv, xv, ev;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.y_in  = 32'd0;
    bus.x_in  = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy",   32'(bus.busy), 32'd0);
    check_eq("rst_done",   32'(bus.done), 32'd0);
    check_eq("rst_error",  32'(bus.error), 32'd0);
    check_eq("rst_strobe", 32'({bus.fpu_sel, bus.fpu_read, bus.fpu_write}), 32'd0);
    check_eq("rst_addr",   32'(bus.fpu_addr), 32'd0);
    check_eq("rst_wdata",  32'(bus.fpu_wdata), 32'd0);
    check_eq("rst_result", bus.result, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed: 6/2 with three busy polls; 1.5*2; ignored second start during CMD_X.
    run_op("div", 1'b0, 32'h40C00000, 32'h40000000, 3, 32'h40400000, 0);
    run_op("mul", 1'b1, 32'h3FC00000, 32'h40000000, 0, 32'h40400000, 0);
    run_op("ignore", 1'b0, 32'h41000000, 32'h40800000, 1, 32'h40000000, 11);

    // start held high through DONE chains straight into a second operation.
    busy_cfg  = 0;
    bus.op    = 1'b0;
    bus.y_in  = r2f(12.0);
    bus.x_in  = r2f(4.0);
    bus.start = 1'b1;
    cyc = 0;
    do begin @(posedge clk); @(negedge clk); cyc++; end while (!bus.done && cyc < 400);
    check_eq("hold_lat1", 32'(cyc), 32'(33 + SETTLE));
    check_eq("hold_res1", bus.result, r2f(3.0));
    bus.op   = 1'b1;
    bus.y_in = r2f(2.5);
    bus.x_in = r2f(4.0);
    @(posedge clk); @(negedge clk);
    check_eq("hold_idle", 32'(bus.busy), 32'd0);
    @(posedge clk); @(negedge clk);
    check_eq("hold_cmd_y", 32'({bus.fpu_write, bus.fpu_addr, bus.fpu_wdata}), 32'({1'b1, 2'b10, 8'h01}));
    bus.start = 1'b0;
    cyc = 1;
    do begin @(posedge clk); @(negedge clk); cyc++; end while (!bus.done && cyc < 400);
    check_eq("hold_lat2", 32'(cyc), 32'(33 + SETTLE));
    check_eq("hold_res2", bus.result, r2f(10.0));
    last_res = r2f(10.0);
    @(posedge clk); @(negedge clk);

    // Asynchronous reset in the middle of VAL_X, then a clean operation.
    busy_cfg  = 0;
    bus.op    = 1'b0;
    bus.y_in  = r2f(10.0);
    bus.x_in  = r2f(5.0);
    bus.start = 1'b1;
    cyc = 0;
    do begin @(posedge clk); @(negedge clk); cyc++; bus.start = 1'b0; end while (cyc < 15);
    check_eq("valx_strobe", 32'({bus.fpu_sel, bus.fpu_write, bus.fpu_addr, bus.fpu_wdata}),
             32'({1'b1, 1'b1, 2'b11, 8'hA0}));
    reset = 1'b1;
    #1;
    check_eq("arst_strobes", 32'({bus.fpu_sel, bus.fpu_read, bus.fpu_write}), 32'd0);
    check_eq("arst_busy",    32'(bus.busy), 32'd0);
    check_eq("arst_result",  bus.result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_op("after_rst", 1'b0, r2f(10.0), r2f(5.0), 0, r2f(2.0), 0);

    // Randomized operations on exactly representable values.
    for (int n = 0; n < 8; n++) begin
      a   = $urandom_range(1, 200);
      b   = $urandom_range(1, 64);
      opv = 1'($urandom_range(0, 1));
      bn  = $urandom_range(0, 3);
      if (opv) begin
        yv = r2f(real'(a) * 0.25);
        xv = r2f(real'(b));
        ev = r2f(real'(a * b) * 0.25);
      end else begin
        yv = r2f(real'(a * b) * 0.25);
        xv = r2f(real'(b));
        ev = r2f(real'(a) * 0.25);
      end
      run_op($sformatf("rnd%0d", n), opv, yv, xv, bn, ev, 0);
    end

`ifdef FPU_HOST_TIMEOUT_EN
    // FPU never finishes: error and done after POLL_LIMIT polls, result untouched.
    wr_q.delete();
    busy_cfg     = 0;
    busy_forever = 1'b1;
    status_reads = 0;
    bus.op    = 1'b0;
    bus.y_in  = r2f(9.0);
    bus.x_in  = r2f(3.0);
    bus.start = 1'b1;
    cyc = 0;
    do begin @(posedge clk); @(negedge clk); cyc++; bus.start = 1'b0; end while (!bus.done && cyc < 400);
    check_eq("to_latency", 32'(cyc), 32'(31 + SETTLE));
    check_eq("to_error",   32'(bus.error), 32'd1);
    check_eq("to_result",  bus.result, last_res);
    check_eq("to_polls",   32'(status_reads), 32'(POLL_LIMIT));
    @(posedge clk); @(negedge clk);
    check_eq("to_err_held", 32'(bus.error), 32'd1);
    busy_forever = 1'b0;
    run_op("to_recover", 1'b0, r2f(9.0), r2f(3.0), 0, r2f(3.0), 0);
`else
    // More busy polls than POLL_LIMIT: without the timeout the host keeps polling.
    run_op("slow", 1'b1, r2f(3.0), r2f(7.0), 6, r2f(21.0), 0);
    check_eq("slow_error", 32'(bus.error), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fpu_host.md
FPU_HOST -- requirements
Module: fpu_host

Interface
REQ-001 SHALL have parameter: SETTLE, default 2, idle cycles after the operation command before the first status poll.
REQ-002 SHALL have parameter: POLL_LIMIT, default 255, maximum status polls per operation (used only under FPU_HOST_TIMEOUT_EN).
REQ-003 SHALL have port: clk  in  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port: start  in  1  request; sampled only in IDLE.
REQ-006 SHALL have port: op  in  1  0 = divide Y/X, 1 = multiply Y*X.
REQ-007 SHALL have ports: y_in, x_in  in  32  IEEE-754 single operands.
REQ-008 SHALL have port: busy  out  1  high in every state except IDLE.
REQ-009 SHALL have port: done  out  1  one-cycle pulse when result is valid.
REQ-010 SHALL have port: result  out  32  last completed result, held until next done.
REQ-011 SHALL have port: error  out  1  timeout flag (driven 0 when FPU_HOST_TIMEOUT_EN is undefined).
REQ-012 SHALL have ports: fpu_sel, fpu_read, fpu_write  out  1  FPU bus select and strobes.
REQ-013 SHALL have ports: fpu_addr  out  2 (00 status, 01 result, 10 command, 11 value); fpu_wdata  out  8.
REQ-014 SHALL have port: fpu_rdata  in  8  FPU read data.

Function
REQ-015 Every bus access SHALL be two cycles: strobe phase (fpu_sel=1, one strobe=1, addr/wdata valid) then gap phase (fpu_sel, fpu_read, fpu_write all 0).
REQ-016 fpu_read and fpu_write SHALL never be high together; fpu_wdata SHALL be 0 outside write strobe phases.
REQ-017 In IDLE with start=1, y_in, x_in and op SHALL be latched and the FSM SHALL enter CMD_Y next cycle.
REQ-018 FSM SHALL be IDLE -> CMD_Y -> VAL_Y -> CMD_X -> VAL_X -> CMD_OP -> SETTLE -> POLL -> READ -> DONE -> IDLE.
REQ-019 CMD_Y SHALL write command 0x01; CMD_X command 0x02; CMD_OP command 0x03 (op=0) or 0x04 (op=1), all at addr 10.
REQ-020 VAL_Y/VAL_X SHALL write four bytes at addr 11, most-significant byte first, via a 2-bit byte counter that wraps 3 -> 0 on state exit.
REQ-021 SETTLE SHALL last exactly SETTLE cycles with all strobes low.
REQ-022 POLL SHALL read addr 00, sample fpu_rdata[7] in the strobe phase; 1 = repeat poll, 0 = enter READ.
REQ-023 READ SHALL read addr 01 four times, capturing fpu_rdata in the strobe phase into result bits [31:24], [23:16], [15:8], [7:0] in order.
REQ-024 result SHALL update only on entry to DONE; done SHALL be high exactly during DONE (one cycle).
REQ-025 Latency from start sample to done with one poll SHALL be 2+8+2+8+2+SETTLE+2+8+1 = 33+SETTLE cycles; each extra poll adds 2.
REQ-026 start while busy=1 SHALL be ignored, with latched operands unchanged.
REQ-027 start held high through DONE SHALL begin a new operation on the IDLE cycle after DONE.

Reset
REQ-028 reset SHALL immediately force IDLE and set busy, done, error, fpu_sel, fpu_read, fpu_write to 0, fpu_addr, fpu_wdata and result to 0, and clear all counters.
REQ-029 reset mid-operation SHALL abort without completing the bus access; the next operation's leading 0x01 command re-synchronises the FPU.

Configuration
REQ-030 With macro FPU_HOST_TIMEOUT_EN defined, an 8-bit poll counter SHALL count polls; when POLL_LIMIT polls all read busy, the FSM SHALL set error=1, leave result unchanged, pulse done and return to IDLE.
REQ-031 error SHALL clear on the next accepted start.
REQ-032 Without FPU_HOST_TIMEOUT_EN, the counter and logic SHALL be absent, POLL SHALL repeat indefinitely and error SHALL be constant 0.

Verification
REQ-033 Divide: op=0, y_in=0x40C00000, x_in=0x40000000, FPU model busy 3 polls -> done pulse, result=0x40400000, error=0.
REQ-034 Multiply: op=1, y_in=0x3FC00000, x_in=0x40000000 -> result=0x40400000; bus trace shows write 0x04 at addr 10.
REQ-035 Bus trace for Y=0x40C00000: writes (10,01),(11,40),(11,C0),(11,00),(11,00), each strobe high one cycle followed by a gap cycle.
REQ-036 Second start asserted in CMD_X with different operands -> ignored; FPU receives only first operands; one done pulse.
REQ-037 reset asserted in VAL_X -> all strobes 0 in same cycle; a subsequent start completes with the correct result.
REQ-038 FPU_HOST_TIMEOUT_EN defined, model busy forever, POLL_LIMIT=4 -> error=1 and done after 4th poll; result unchanged.
